axis_rr_stream_arbiter: RTL and testbench

//  Shares one 256-bit AXI-Stream sink (normally the axis_sync_fifo input) between NUM_SRC producers.

---
 rtl/axis_rr_stream_arbiter_pkg.sv | 8 +
 rtl/axis_rr_stream_arbiter_skid_buf.sv | 66 ++++++
 rtl/axis_rr_stream_arbiter.sv | 110 +++++++++++
 tb/tb_axis_rr_stream_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_stream_arbiter_pkg.sv
// Shared types and constants for the round-robin AXI-Stream arbiter.
package axis_rr_stream_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int AXIS_DATA_W = 256;

endpackage

// File: rtl/axis_rr_stream_arbiter_skid_buf.sv
// Two-entry fully registered valid/ready buffer; head entry drives the output.
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic         push, pop;

    // Simultaneous push and pop is only possible with one entry held, so the new beat replaces the head.
    always_comb begin
        push    = in_valid && ready_q;
        pop     = valid_q && out_ready;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data;
                else                 tail_d = in_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: head_d = in_data;
            default: ;
        endcase
        ready_d = (count_d != 2'd2);
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = head_q;

endmodule

// File: rtl/axis_rr_stream_arbiter.sv
// Round-robin arbiter with a burst cap sharing one AXI-Stream sink among NUM_SRC sources.
module axis_rr_stream_arbiter
    import axis_rr_stream_arbiter_pkg::*;
#(
    parameter  int NUM_SRC   = 4,
    parameter  int DATA_W    = AXIS_DATA_W,
    parameter  int MAX_BURST = 16,
    localparam int ID_W      = $clog2(NUM_SRC)
) (
    input  logic                      axis_clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [ID_W-1:0]           m_axis_tid,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              skid_in_ready;
    logic              src_valid;
    logic              xfer;
    logic [DATA_W-1:0] src_data;

    // Rotate so the source after the last grant sits at bit 0, take the lowest set bit, rotate back.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                input logic [ID_W-1:0]    last);
        logic [2*NUM_SRC-1:0] dbl;
        logic [NUM_SRC-1:0]   rot;
        int                   start;
        int                   off;
        start = (int'(last) + 1) % NUM_SRC;
        dbl   = {req, req};
        rot   = dbl[start +: NUM_SRC];
        off   = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        return ID_W'((start + off) % NUM_SRC);
    endfunction

    always_comb begin
        src_valid     = s_axis_tvalid[grant_q];
        src_data      = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
        s_axis_tready = '0;
        if (state_q == ARB_GRANT) s_axis_tready[grant_q] = skid_in_ready;
        xfer = (state_q == ARB_GRANT) && src_valid && skid_in_ready;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d    = rr_pick(s_axis_tvalid, grant_q);
                    beat_cnt_d = '0;
                    state_d    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!src_valid) begin
                    state_d = ARB_IDLE;
                end else if (skid_in_ready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= ID_W'(NUM_SRC - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    axis_skid_buf #(
        .W(DATA_W + ID_W)
    ) u_skid (
        .clk      (axis_clk),
        .rst      (rst),
        .in_valid (xfer),
        .in_ready (skid_in_ready),
        .in_data  ({grant_q, src_data}),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready),
        .out_data ({m_axis_tid, m_axis_tdata})
    );

    assign busy     = (state_q == ARB_GRANT);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_axis_rr_stream_arbiter.sv
// Scoreboard bench for axis_rr_stream_arbiter: directed source streams, queued expected beats.
module tb_axis_rr_stream_arbiter;

    localparam int NUM_SRC   = 4;
    localparam int DATA_W    = 256;
    localparam int MAX_BURST = 16;
    localparam int ID_W      = 2;

    logic                      axis_clk;
    logic                      rst;
    logic [NUM_SRC-1:0]        s_axis_tvalid;
    logic [NUM_SRC-1:0]        s_axis_tready;
    logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic [DATA_W-1:0]         m_axis_tdata;
    logic [ID_W-1:0]           m_axis_tid;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;

    int tests_run    = 0;
    int tests_failed = 0;

    bit src_en  [NUM_SRC];
    int src_len [NUM_SRC];
    int src_pos [NUM_SRC];

    logic [ID_W+DATA_W-1:0] exp_q[$];

    axis_rr_stream_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .axis_clk     (axis_clk),
        .rst          (rst),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tid   (m_axis_tid),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    initial begin
        axis_clk = 1'b0;
        forever #5 axis_clk = ~axis_clk;
    end

    function automatic logic [DATA_W-1:0] make_word(input int src, input int n);
        logic [31:0] chunk;
        chunk = {16'hA5C3 ^ 16'(src), 16'(n)};
        return {8{chunk}};
    endfunction

    task automatic checkOutput(input string name, input logic [263:0] actual,
                               input logic [263:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_SRC; i++) begin
            s_axis_tvalid[i] = src_en[i] && (src_pos[i] < src_len[i]);
            s_axis_tdata[i*DATA_W +: DATA_W] = make_word(i, src_pos[i]);
        end
    endtask

    // Handshakes are sampled mid-cycle and retired just after the edge that completes them.
    task automatic tick();
        logic [NUM_SRC-1:0] fire;
        @(negedge axis_clk);
        fire = s_axis_tvalid & s_axis_tready;
        @(posedge axis_clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) if (fire[i]) src_pos[i]++;
        applyStimulus();
    endtask

    task automatic expect_beats(input int src, input int first, input int count);
        for (int n = first; n < first + count; n++) exp_q.push_back({ID_W'(src), make_word(src, n)});
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NUM_SRC; i++) begin
            src_en[i]  = 1'b0;
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        exp_q.delete();
        applyStimulus();
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        m_axis_tready = 1'b0;
        clear_sources();
        @(posedge axis_clk);
        @(posedge axis_clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic enable_src(input int src, input int len);
        src_en[src]  = 1'b1;
        src_len[src] = len;
        applyStimulus();
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 500 && exp_q.size() != 0; c++) tick();
        checkOutput(name, 264'(exp_q.size()), 264'd0);
    endtask

    // Every presented output beat, stalled or not, must match the oldest outstanding expected beat.
    initial begin
        forever begin
            @(negedge axis_clk);
            if (rst && m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL sb_unexpected: got tid=%0d data=%h, expected no beat",
                             m_axis_tid, m_axis_tdata);
                end else begin
                    checkOutput("sb_beat", {m_axis_tid, m_axis_tdata}, exp_q[0]);
                    if (m_axis_tready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int first_busy;
        int last_busy;
        int busy_cnt;
        int grants;
        logic prev_busy;

        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        do_reset();

        // T1: async reset mid-burst with two beats held in the skid buffer
        m_axis_tready = 1'b0;
        enable_src(1, 8);
        expect_beats(1, 0, 8);
        repeat (4) tick();
        checkOutput("T1 beats accepted before reset", 264'(src_pos[1]), 264'd2);
        checkOutput("T1 busy before reset", 264'(busy), 264'd1);
        checkOutput("T1 grant before reset", 264'(grant_id), 264'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("T1 reset m_tvalid", 264'(m_axis_tvalid), 264'd0);
        checkOutput("T1 reset m_tdata", 264'(m_axis_tdata), 264'd0);
        checkOutput("T1 reset m_tid", 264'(m_axis_tid), 264'd0);
        checkOutput("T1 reset busy", 264'(busy), 264'd0);
        checkOutput("T1 reset grant_id", 264'(grant_id), 264'd3);
        checkOutput("T1 reset s_tready", 264'(s_axis_tready), 264'd0);
        clear_sources();
        enable_src(0, 3);
        enable_src(1, 3);
        expect_beats(0, 0, 3);
        expect_beats(1, 0, 3);
        @(posedge axis_clk);
        #1;
        checkOutput("T1 no handshake in reset", 264'(s_axis_tready), 264'd0);
        rst           = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        checkOutput("T1 first grant busy", 264'(busy), 264'd1);
        checkOutput("T1 first grant src0", 264'(grant_id), 264'd0);
        drain("T1 drain");

        // T2: four always-valid sources, full bursts, one idle bubble between grants
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) enable_src(i, 2 * MAX_BURST);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_SRC; i++) expect_beats(i, r * MAX_BURST, MAX_BURST);
        first_busy = -1;
        last_busy  = -1;
        busy_cnt   = 0;
        for (int c = 0; c < 600 && exp_q.size() != 0; c++) begin
            tick();
            if (busy) begin
                if (first_busy < 0) first_busy = c;
                last_busy = c;
                busy_cnt++;
            end
        end
        checkOutput("T2 drain", 264'(exp_q.size()), 264'd0);
        checkOutput("T2 busy cycles", 264'(busy_cnt), 264'd128);
        checkOutput("T2 grant span", 264'(last_busy - first_busy + 1), 264'd135);

        // T3: src2 releases early after five beats, src3 waits its turn
        do_reset();
        m_axis_tready = 1'b1;
        enable_src(2, 5);
        enable_src(3, 4);
        expect_beats(2, 0, 5);
        expect_beats(3, 0, 4);
        for (int c = 0; c < 50 && src_pos[2] != 5; c++) tick();
        checkOutput("T3 src2 sent five", 264'(src_pos[2]), 264'd5);
        tick();
        checkOutput("T3 idle after drop", 264'(busy), 264'd0);
        tick();
        checkOutput("T3 src3 busy", 264'(busy), 264'd1);
        checkOutput("T3 src3 granted", 264'(grant_id), 264'd3);
        drain("T3 drain");

        // T4: downstream ready pattern 1,0,0,1 while src1 streams 64 beats
        do_reset();
        enable_src(1, 64);
        expect_beats(1, 0, 64);
        grants    = 0;
        prev_busy = 1'b0;
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) begin
            m_axis_tready = (k % 4 == 0) || (k % 4 == 3);
            tick();
            if (busy && !prev_busy) grants++;
            prev_busy = busy;
        end
        checkOutput("T4 drain", 264'(exp_q.size()), 264'd0);
        checkOutput("T4 grant count", 264'(grants), 264'd4);

        // T5: lone src3, idle gap, then lone src0
        do_reset();
        m_axis_tready = 1'b1;
        enable_src(3, 3);
        expect_beats(3, 0, 3);
        tick();
        checkOutput("T5 src3 granted", 264'(grant_id), 264'd3);
        drain("T5 drain src3");
        repeat (2) tick();
        checkOutput("T5 idle busy", 264'(busy), 264'd0);
        checkOutput("T5 idle s_tready", 264'(s_axis_tready), 264'd0);
        checkOutput("T5 idle m_tvalid", 264'(m_axis_tvalid), 264'd0);
        enable_src(0, 2);
        expect_beats(0, 0, 2);
        tick();
        checkOutput("T5 wrap busy", 264'(busy), 264'd1);
        checkOutput("T5 wrap to src0", 264'(grant_id), 264'd0);
        drain("T5 drain src0");

        // T6: the sixteenth beat of a grant stalls on a full skid buffer
        do_reset();
        m_axis_tready = 1'b1;
        enable_src(0, 20);
        enable_src(1, 4);
        expect_beats(0, 0, MAX_BURST);
        expect_beats(1, 0, 4);
        expect_beats(0, MAX_BURST, 4);
        for (int c = 0; c < 50 && src_pos[0] != 14; c++) tick();
        checkOutput("T6 reached beat 14", 264'(src_pos[0]), 264'd14);
        m_axis_tready = 1'b0;
        repeat (5) tick();
        checkOutput("T6 stalled count", 264'(src_pos[0]), 264'd15);
        checkOutput("T6 stall busy", 264'(busy), 264'd1);
        checkOutput("T6 stall grant", 264'(grant_id), 264'd0);
        checkOutput("T6 stall s_tready", 264'(s_axis_tready), 264'd0);
        m_axis_tready = 1'b1;
        for (int c = 0; c < 10 && src_pos[0] != 16; c++) tick();
        checkOutput("T6 cap beat taken", 264'(src_pos[0]), 264'd16);
        checkOutput("T6 idle after cap", 264'(busy), 264'd0);
        tick();
        checkOutput("T6 next grant src1", 264'(grant_id), 264'd1);
        drain("T6 drain");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
